alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle control sequencer for the bus-based arithmetic processor. It owns the program counter, accepts 16-bit instructions from program memory over a valid/ready handshake, and steps each one through its execution cycles. In each cycle it drives the shared-bus control lines: the A-register enable, the G-register enable and output, the ALU select, external input, register write and tri-state source. It replaces hand-sequenced state stimulus and sits between program memory and the register/ALU datapath.

## Interface
- NREG, 8, number of general registers; register indices ≥ NREG are invalid
- PC_W, 8, program counter width
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- instr_valid  in  1  program memory presents an instruction
- instr_ready  out  1  sequencer can accept an instruction
- instr  in  16  instruction: [15:12] opcode, [11:8] Rx, [7:4] Ry
- ext_valid  in  1  external data word is present on the bus input path
- bus  in  16  current shared-bus value; used by branch
- pc  out  PC_W  program counter
- read_addr  out  1  datapath drives the zero-extended pc onto the bus
- aen, gen, gout  out  1 each  A-register load, G-register load, G tri-state enable
- sel  out  3  ALU function: add 000, xor 001, sub 010, mul 011, div 100, ones 101
- extern  out  1  external data drives the bus
- reg_wr_en  out  1; reg_wr_idx  out  4  register load strobe and index
- tri_en  out  1; tri_idx  out  4  register tri-state enable and index
- retire  out  1  one-cycle pulse in an instruction's last execute cycle
- busy  out  1  high in any state other than FETCH

## Operation
- Registered state is one of FETCH, EX1, EX2 or EX3. A 16-bit instruction register (IR) and pc are also registered.
- All control outputs are combinational decodes of state and IR. Any enable not listed for a state is 0. Idle indices are 4'h0, never x.
- FETCH: instr_ready=1. When instr_valid=1, IR<=instr and state goes to EX1. Otherwise the state stays in FETCH.
- Opcodes and their execute sequences:
  - 0 load (EX1): waits in EX1 while ext_valid=0 with every enable 0. When ext_valid=1: extern=1, reg_wr Rx, retire.
  - 1 move (EX1): tri Ry, reg_wr Rx, retire.
  - 2 ldpc (EX1): read_addr=1, reg_wr Rx, retire.
  - 3 branch (EX1): tri Rx, pc<=bus[PC_W-1:0] instead of pc+1, retire.
  - 4–8 add/xor/sub/mul/div:
    - EX1: tri Rx, aen.
    - EX2: tri Ry, gen, sel per opcode.
    - EX3: gout, reg_wr Rx, retire.
  - 9 ones:
    - EX1: tri Rx, aen.
    - EX2: tri Rx, gen, sel=101.
    - EX3: gout, reg_wr R0, retire.
  - 10–15 illegal (EX1): no enables, retire.
- On retire the next state is FETCH and pc<=pc+1 (branch excepted). pc wraps from 2^PC_W−1 to 0.
- Any Rx/Ry ≥ NREG forces the corresponding reg_wr_en/tri_en to 0. The sequence and retire proceed unchanged.
- tri_en and extern/read_addr/gout are mutually exclusive in every state. At most one bus driver is active.

## Timing
- resetn low (asynchronous): state=FETCH, IR=0, pc=0. Outputs: instr_ready=1, busy=0, retire=0, all enables 0, sel=000, indices 0.
- Reset asserted mid-instruction aborts it. No retire is issued and pc is not advanced.
- Accept cycle = the cycle with instr_valid & instr_ready. EX1 is the next cycle.
- Single-cycle ops: instr_ready returns 2 cycles after accept, or later for load while ext_valid=0.
- ALU ops and ones: instr_ready returns 4 cycles after accept.
- Back-to-back: with instr_valid held high, a new instruction is accepted every 2 (single) or 4 (ALU) cycles with no bubble.
- pc updates on the clock edge that ends the retire cycle. It is visible in the following FETCH.
- instr and instr_valid are ignored outside FETCH. bus is sampled only in branch EX1. ext_valid is sampled only in load EX1.

## Test plan
- Reset, then accept 0x4120 (add R1,R2):
  - EX1: tri_idx=1, aen=1.
  - EX2: tri_idx=2, gen=1, sel=000.
  - EX3: gout=1, reg_wr_idx=1, retire=1.
  - Then pc=1 and instr_ready=1.
- load 0x0300 with ext_valid low for 5 cycles then high: stays in EX1 with extern=0 for 5 cycles, then extern=1, reg_wr_idx=3, retire in the same cycle.
- branch 0x3500 with bus=16'h00A7: EX1 tri_idx=5, retire. Next FETCH pc=0xA7. Then branch with bus=0x00FF followed by move: pc goes from 0xFF to 0x00.
- ones 0x9400: EX2 sel=101, tri_idx=4. EX3 reg_wr_idx=0. Also move 0x1A20 with NREG=8: reg_wr_en=0, tri_en=1, retire, pc+1.
- Stream of illegal opcode 0xF000 with instr_valid always high: accept every 2 cycles, no enables, pc increments by 1 each instruction.
- Drop resetn during mul EX2 (opcode 7): outputs immediately return to reset values, pc=0, no retire. First instruction after release is accepted normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle control sequencer driving the shared-bus ALU datapath
module alu_op_sequencer #(
    parameter int NREG = 8,
    parameter int PC_W = 8
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [15:0]     instr,
    input  logic            ext_valid,
    input  logic [15:0]     bus,
    output logic [PC_W-1:0] pc,
    output logic            read_addr,
    output logic            aen,
    output logic            gen,
    output logic            gout,
    output logic [2:0]      sel,
    output logic            extern_en,
    output logic            reg_wr_en,
    output logic [3:0]      reg_wr_idx,
    output logic            tri_en,
    output logic [3:0]      tri_idx,
    output logic            retire,
    output logic            busy
);

    typedef enum logic [1:0] {S_FETCH, S_EX1, S_EX2, S_EX3} state_t;

    localparam logic [4:0] NREG_W  = 5'(NREG);
    localparam logic [3:0] OP_ONES = 4'd9;

    state_t          state_q, state_d;
    logic [15:0]     ir_q, ir_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic [3:0] op, rx, ry;
    logic       wr_cand, tri_cand, jump;
    logic [3:0] wr_idx_c, tri_idx_c;
    logic       unused_bits;

    assign op = ir_q[15:12];
    assign rx = ir_q[11:8];
    assign ry = ir_q[7:4];
    assign pc = pc_q;
    assign unused_bits = ^{ir_q[3:0], bus};

    function automatic logic idx_ok(input logic [3:0] idx);
        return {1'b0, idx} < NREG_W;
    endfunction

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        instr_ready = 1'b0;
        read_addr   = 1'b0;
        aen         = 1'b0;
        gen         = 1'b0;
        gout        = 1'b0;
        sel         = 3'b000;
        extern_en   = 1'b0;
        retire      = 1'b0;
        wr_cand     = 1'b0;
        wr_idx_c    = 4'h0;
        tri_cand    = 1'b0;
        tri_idx_c   = 4'h0;
        jump        = 1'b0;

        case (state_q)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_EX1;
                end
            end
            S_EX1: begin
                case (op)
                    4'd0: begin
                        // load parks here until the external word shows up
                        if (ext_valid) begin
                            extern_en = 1'b1;
                            wr_cand   = 1'b1;
                            wr_idx_c  = rx;
                            retire    = 1'b1;
                        end
                    end
                    4'd1: begin
                        tri_cand  = 1'b1;
                        tri_idx_c = ry;
                        wr_cand   = 1'b1;
                        wr_idx_c  = rx;
                        retire    = 1'b1;
                    end
                    4'd2: begin
                        read_addr = 1'b1;
                        wr_cand   = 1'b1;
                        wr_idx_c  = rx;
                        retire    = 1'b1;
                    end
                    4'd3: begin
                        tri_cand  = 1'b1;
                        tri_idx_c = rx;
                        jump      = 1'b1;
                        retire    = 1'b1;
                    end
                    4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                        tri_cand  = 1'b1;
                        tri_idx_c = rx;
                        aen       = 1'b1;
                        state_d   = S_EX2;
                    end
                    default: retire = 1'b1;
                endcase
            end
            S_EX2: begin
                gen      = 1'b1;
                tri_cand = 1'b1;
                state_d  = S_EX3;
                if (op == OP_ONES) begin
                    sel       = 3'b101;
                    tri_idx_c = rx;
                end else begin
                    sel       = 3'(op - 4'd4);
                    tri_idx_c = ry;
                end
            end
            S_EX3: begin
                gout     = 1'b1;
                wr_cand  = 1'b1;
                wr_idx_c = (op == OP_ONES) ? 4'h0 : rx;
                retire   = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        if (retire) begin
            state_d = S_FETCH;
            pc_d    = jump ? bus[PC_W-1:0] : pc_q + PC_W'(1);
        end

        // out-of-range register indices suppress only the strobe, never the sequence
        reg_wr_en  = wr_cand && idx_ok(wr_idx_c);
        reg_wr_idx = reg_wr_en ? wr_idx_c : 4'h0;
        tri_en     = tri_cand && idx_ok(tri_idx_c);
        tri_idx    = tri_en ? tri_idx_c : 4'h0;
        busy       = (state_q != S_FETCH);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_FETCH;
            ir_q    <= 16'h0000;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
    localparam int NREG = 8;
    localparam int PC_W = 8;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic            instr_valid = 1'b0;
    logic            ext_valid = 1'b0;
    logic [15:0]     instr = 16'h0;
    logic [15:0]     bus = 16'h0;
    logic            instr_ready, read_addr, aen, gen, gout, extern_en;
    logic            reg_wr_en, tri_en, retire, busy;
    logic [2:0]      sel;
    logic [3:0]      reg_wr_idx, tri_idx;
    logic [PC_W-1:0] pc;

    int n_tests = 0;
    int n_fail  = 0;
    int m_pc    = 0;

    alu_op_sequencer #(.NREG(NREG), .PC_W(PC_W)) dut (
        .clock(clock), .resetn(resetn),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .ext_valid(ext_valid), .bus(bus), .pc(pc),
        .read_addr(read_addr), .aen(aen), .gen(gen), .gout(gout), .sel(sel),
        .extern_en(extern_en), .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx),
        .tri_en(tri_en), .tri_idx(tri_idx), .retire(retire), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [20:0] obs();
        return {instr_ready, busy, read_addr, aen, gen, gout, extern_en, sel,
                reg_wr_en, reg_wr_idx, tri_en, tri_idx, retire};
    endfunction

    // Expected control word for execute step 'phase' (0 = fetch) of an instruction
    function automatic logic [20:0] exp_vec(input int phase, input logic [15:0] ins, input logic ev);
        int op = int'(ins[15:12]);
        int rx = int'(ins[11:8]);
        int ry = int'(ins[7:4]);
        bit rd = 0, a = 0, g = 0, go = 0, ex = 0, we = 0, te = 0, ret = 0;
        int s = 0, wi = 0, ti = 0;
        if (phase == 1) begin
            if (op == 0) begin
                if (ev) begin ex = 1; we = 1; wi = rx; ret = 1; end
            end else if (op == 1) begin te = 1; ti = ry; we = 1; wi = rx; ret = 1; end
            else if (op == 2) begin rd = 1; we = 1; wi = rx; ret = 1; end
            else if (op == 3) begin te = 1; ti = rx; ret = 1; end
            else if (op <= 9) begin te = 1; ti = rx; a = 1; end
            else ret = 1;
        end else if (phase == 2) begin
            g = 1; te = 1;
            s  = (op == 9) ? 5 : op - 4;
            ti = (op == 9) ? rx : ry;
        end else if (phase == 3) begin
            go = 1; we = 1; ret = 1;
            wi = (op == 9) ? 0 : rx;
        end
        if (wi >= NREG) we = 0;
        if (ti >= NREG) te = 0;
        if (!we) wi = 0;
        if (!te) ti = 0;
        return {phase == 0, phase != 0, rd, a, g, go, ex, 3'(s), we, 4'(wi), te, 4'(ti), ret};
    endfunction

    function automatic int exp_cycles(input logic [15:0] ins, input int ext_wait);
        int op = int'(ins[15:12]);
        if (op == 0) return ext_wait + 2;
        if (op >= 4 && op <= 9) return 4;
        return 2;
    endfunction

    // Runs one instruction from its fetch cycle to retire, checking every cycle
    task automatic do_instr(input logic [15:0] ins, input int ext_wait, input logic [15:0] busv,
                            input bit hold, input string tag, output int cycles);
        int phase = 0;
        int waits = 0;
        bit done = 0;
        logic [20:0] e, o;
        int op = int'(ins[15:12]);
        cycles = 0;
        while (!done && cycles < 40) begin
            @(negedge clock);
            if (phase == 0) begin
                instr_valid = 1'b1;
                instr = ins;
            end else begin
                instr_valid = hold ? 1'b1 : 1'($urandom);
                instr = 16'($urandom);
            end
            ext_valid = (op == 0 && phase == 1) ? (waits >= ext_wait) : 1'($urandom);
            bus = (op == 3 && phase == 1) ? busv : 16'($urandom);
            #1;
            e = exp_vec(phase, ins, ext_valid);
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s ctrl ph%0d cyc%0d: got %h want %h", tag, phase, cycles, o, e);
            end
            n_tests++;
            if (pc !== PC_W'(m_pc)) begin
                n_fail++;
                $display("FAIL %s pc ph%0d: got %h want %h", tag, phase, pc, PC_W'(m_pc));
            end
            n_tests++;
            if (int'(tri_en) + int'(extern_en) + int'(read_addr) + int'(gout) > 1) begin
                n_fail++;
                $display("FAIL %s bus_drivers ph%0d: got %b%b%b%b want at most one",
                         tag, phase, tri_en, extern_en, read_addr, gout);
            end
            cycles++;
            if (phase == 0) phase = 1;
            else if (e[0]) begin
                m_pc = (op == 3) ? int'(busv[PC_W-1:0]) : (m_pc + 1) % (1 << PC_W);
                done = 1;
            end else if (op == 0) waits++;
            else phase++;
        end
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: got no retire want retire within 40 cycles", tag);
        end
    endtask

    task automatic idle_check_pc(input string tag, input int want);
        @(negedge clock);
        instr_valid = 1'b0;
        #1;
        n_tests++;
        if (pc !== PC_W'(want) || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got pc=%h ready=%b want pc=%h ready=1", tag, pc, instr_ready, PC_W'(want));
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        #1;
        n_tests++;
        if (obs() !== exp_vec(0, 16'h0, 1'b0) || pc !== '0) begin
            n_fail++;
            $display("FAIL reset: got %h pc=%h want %h pc=0", obs(), pc, exp_vec(0, 16'h0, 1'b0));
        end
        @(negedge clock);
        resetn = 1'b1;
        m_pc = 0;
    endtask

    task automatic test_add();
        int c;
        do_instr(16'h4120, 0, 16'h0, 1'b0, "add", c);
        n_tests++;
        if (c !== 4) begin n_fail++; $display("FAIL add_cycles: got %0d want 4", c); end
        idle_check_pc("add_pc", 1);
    endtask

    task automatic test_load();
        int c;
        do_instr(16'h0300, 5, 16'h0, 1'b0, "load", c);
        n_tests++;
        if (c !== 7) begin n_fail++; $display("FAIL load_cycles: got %0d want 7", c); end
    endtask

    task automatic test_branch();
        int c;
        do_instr(16'h3500, 0, 16'h00A7, 1'b0, "branch_a7", c);
        idle_check_pc("branch_pc_a7", 'hA7);
        do_instr(16'h3100, 0, 16'h00FF, 1'b0, "branch_ff", c);
        do_instr(16'h1120, 0, 16'h0, 1'b0, "move_wrap", c);
        idle_check_pc("pc_wrap", 0);
    endtask

    task automatic test_ones_nreg();
        int c;
        int start = m_pc;
        do_instr(16'h9400, 0, 16'h0, 1'b0, "ones", c);
        do_instr(16'h1A20, 0, 16'h0, 1'b0, "move_bad_rx", c);
        idle_check_pc("ones_nreg_pc", (start + 2) % 256);
    endtask

    task automatic test_back_to_back();
        int c;
        int start = m_pc;
        for (int i = 0; i < 6; i++) begin
            do_instr(16'hF000, 0, 16'h0, 1'b1, "illegal_stream", c);
            n_tests++;
            if (c !== 2) begin n_fail++; $display("FAIL b2b_cycles[%0d]: got %0d want 2", i, c); end
        end
        idle_check_pc("b2b_pc", (start + 6) % 256);
    endtask

    task automatic test_random();
        int c, w;
        logic [15:0] ins;
        for (int i = 0; i < 60; i++) begin
            ins = 16'($urandom);
            w = (ins[15:12] == 4'd0) ? int'($urandom_range(0, 3)) : 0;
            do_instr(ins, w, 16'($urandom), 1'($urandom), "random", c);
            n_tests++;
            if (c !== exp_cycles(ins, w)) begin
                n_fail++;
                $display("FAIL random_cycles %h: got %0d want %0d", ins, c, exp_cycles(ins, w));
            end
        end
    endtask

    task automatic test_reset_abort();
        int c;
        @(negedge clock);
        instr_valid = 1'b1;
        instr = 16'h7120;
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        #1;
        n_tests++;
        if (gen !== 1'b1 || sel !== 3'b011 || tri_idx !== 4'd2) begin
            n_fail++;
            $display("FAIL mul_ex2: got gen=%b sel=%b tri=%h want gen=1 sel=011 tri=2", gen, sel, tri_idx);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (obs() !== exp_vec(0, 16'h0, 1'b0) || pc !== '0) begin
            n_fail++;
            $display("FAIL abort_async: got %h pc=%h want %h pc=0", obs(), pc, exp_vec(0, 16'h0, 1'b0));
        end
        @(negedge clock);
        #1;
        n_tests++;
        if (retire !== 1'b0 || busy !== 1'b0 || pc !== '0) begin
            n_fail++;
            $display("FAIL abort_hold: got retire=%b busy=%b pc=%h want 0 0 0", retire, busy, pc);
        end
        resetn = 1'b1;
        m_pc = 0;
        do_instr(16'h2300, 0, 16'h0, 1'b0, "after_abort", c);
        idle_check_pc("after_abort_pc", 1);
    endtask

    initial begin
        test_reset();
        test_add();
        test_load();
        test_branch();
        test_ones_nreg();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
